// File: rtl/audio_i2s_tx.sv
// Stereo left-justified I2S-style transmitter fed through a small rts/rtr sample FIFO.
// One sample is popped per 32-slot frame; an empty FIFO at frame start sends zeros and sets a sticky flag.
module audio_i2s_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR        = 2,
    parameter int HALF_DIV   = 4
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic [31:0]    aud_in,
    input  logic           aud_in_rts,
    output logic           aud_in_rtr,
    input  logic           rf_tx_en,
    input  logic           trig_underrun_flag_clear,
    output logic           ro_underrun_flag,
    output logic [PTR:0]   ro_fifo_level,
    output logic           i2s_sck,
    output logic           i2s_ws,
    output logic           i2s_sd
);
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    typedef enum logic [1:0] {ST_DISABLED, ST_WAIT_FIRST, ST_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR-1:0]   r_wrptr;
    logic [PTR-1:0]   r_rdptr;
    logic [PTR:0]     r_level;
    logic [PTR:0]     w_level_nxt;
    logic             r_rtr;
    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic [4:0]       r_bit;
    logic [31:0]      r_shift;
    logic             r_underrun;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_underrun;
    logic             w_div_wrap;
    logic             w_slot_end;
    logic             w_frame_start;

    assign w_push        = aud_in_rts && r_rtr && rf_tx_en;
    assign w_div_wrap    = (r_div == DIV_W'(HALF_DIV - 1));
    assign w_slot_end    = w_div_wrap && r_sck;
    assign w_frame_start = w_slot_end && (r_bit == 5'd31);
    assign w_level_nxt   = r_level + {{PTR{1'b0}}, w_push} - {{PTR{1'b0}}, w_pop};

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_underrun  = 1'b0;
        if (!rf_tx_en) begin
            w_state_nxt = ST_DISABLED;
        end else begin
            case (r_state)
                ST_DISABLED: w_state_nxt = ST_WAIT_FIRST;
                ST_WAIT_FIRST: begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_frame_start) begin
                        w_load     = 1'b1;
                        w_pop      = (r_level != '0);
                        w_underrun = (r_level == '0);
                    end
                end
                default: w_state_nxt = ST_DISABLED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= ST_DISABLED;
        else       r_state <= w_state_nxt;
    end

    // NOTE: sample storage has no reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrptr] <= aud_in;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_level <= '0;
            r_rtr   <= 1'b0;
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (!rf_tx_en) begin
            // Disabling flushes the FIFO and abandons any frame in flight.
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_level <= '0;
            r_rtr   <= 1'b0;
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_push) r_wrptr <= r_wrptr + PTR'(1);
            if (w_pop)  r_rdptr <= r_rdptr + PTR'(1);
            r_level <= w_level_nxt;
            r_rtr   <= (w_level_nxt < (PTR+1)'(FIFO_DEPTH));
            if (r_state == ST_RUN) begin
                if (w_div_wrap) begin
                    r_div <= '0;
                    r_sck <= ~r_sck;
                    if (r_sck) r_bit <= r_bit + 5'd1;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end
            if (w_load)
                r_shift <= w_pop ? r_mem[r_rdptr] : '0;
            else if ((r_state == ST_RUN) && w_slot_end)
                r_shift <= {r_shift[30:0], 1'b0};
        end
    end

    // Underrun set wins over a coincident clear pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                         r_underrun <= 1'b0;
        else if (w_underrun)               r_underrun <= 1'b1;
        else if (trig_underrun_flag_clear) r_underrun <= 1'b0;
    end

    assign aud_in_rtr       = r_rtr;
    assign ro_fifo_level    = r_level;
    assign ro_underrun_flag = r_underrun;
    assign i2s_sck          = r_sck;
    assign i2s_ws           = r_bit[4];
    assign i2s_sd           = r_shift[31];

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: frame-timeline reference model with a per-cycle compare,
// plus directed scenarios pinned with hand-computed expectations, then a randomized soak.
module tb_audio_i2s_tx;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR        = 2;
    localparam int HALF_DIV   = 4;
    localparam int SLOT       = 2 * HALF_DIV;
    localparam int FRAME      = 64 * HALF_DIV;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic [31:0]  aud_in = '0;
    logic         aud_in_rts = 1'b0;
    logic         rf_tx_en = 1'b0;
    logic         trig = 1'b0;
    logic         aud_in_rtr;
    logic         ro_underrun_flag;
    logic [PTR:0] ro_fifo_level;
    logic         i2s_sck;
    logic         i2s_ws;
    logic         i2s_sd;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int          n_acc = 0;

    audio_i2s_tx #(.FIFO_DEPTH(FIFO_DEPTH), .PTR(PTR), .HALF_DIV(HALF_DIV)) dut (
        .clk                      (clk),
        .rstb                     (rstb),
        .aud_in                   (aud_in),
        .aud_in_rts               (aud_in_rts),
        .aud_in_rtr               (aud_in_rtr),
        .rf_tx_en                 (rf_tx_en),
        .trig_underrun_flag_clear (trig),
        .ro_underrun_flag         (ro_underrun_flag),
        .ro_fifo_level            (ro_fifo_level),
        .i2s_sck                  (i2s_sck),
        .i2s_ws                   (i2s_ws),
        .i2s_sd                   (i2s_sd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a sample queue plus the elapsed cycle count inside the current frame.
    logic [31:0] m_q[$];
    int          m_mode = 0;      // 0 off, 1 waiting for first sample, 2 streaming
    int          m_t = 0;
    logic [31:0] m_sample = '0;
    logic        m_rtr = 1'b0;
    logic        m_flag = 1'b0;
    logic        m_push;
    logic        m_under;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_q.delete();
            m_mode   = 0;
            m_t      = 0;
            m_sample = '0;
            m_rtr    = 1'b0;
            m_flag   = 1'b0;
        end else begin
            m_push  = aud_in_rts && m_rtr && rf_tx_en;
            m_under = 1'b0;
            if (!rf_tx_en) begin
                m_q.delete();
                m_mode   = 0;
                m_t      = 0;
                m_sample = '0;
            end else begin
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (m_q.size() > 0) begin
                        m_sample = m_q.pop_front();
                        m_mode   = 2;
                        m_t      = 0;
                    end
                end else if (m_t == FRAME - 1) begin
                    m_t = 0;
                    if (m_q.size() > 0) m_sample = m_q.pop_front();
                    else begin
                        m_sample = '0;
                        m_under  = 1'b1;
                    end
                end else begin
                    m_t++;
                end
                if (m_push) m_q.push_back(aud_in);
            end
            m_rtr = rf_tx_en && (m_q.size() < FIFO_DEPTH);
            if (m_under)   m_flag = 1'b1;
            else if (trig) m_flag = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int   slot;
        logic e_sck, e_ws, e_sd;
        slot  = m_t / SLOT;
        e_sck = (m_mode == 2) && ((m_t % SLOT) >= HALF_DIV);
        e_ws  = (m_mode == 2) && (slot >= 16);
        e_sd  = (m_mode == 2) && m_sample[31 - slot];
        check("sck",   32'(i2s_sck),          32'(e_sck));
        check("ws",    32'(i2s_ws),           32'(e_ws));
        check("sd",    32'(i2s_sd),           32'(e_sd));
        check("rtr",   32'(aud_in_rtr),       32'(m_rtr));
        check("flag",  32'(ro_underrun_flag), 32'(m_flag));
        check("level", 32'(ro_fifo_level),    32'(m_q.size()));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) tick(1);
    endtask

    task automatic chk_slot(input int unsigned f, input int s, input logic e_ws, input logic e_sd);
        wait_cyc(f + 32'(s * SLOT + HALF_DIV));
        check($sformatf("a_slot%0d_ws", s),  32'(i2s_ws),  32'(e_ws));
        check($sformatf("a_slot%0d_sd", s),  32'(i2s_sd),  32'(e_sd));
        check($sformatf("a_slot%0d_sck", s), 32'(i2s_sck), 32'd1);
    endtask

    task automatic push_until(input int unsigned c);
        logic acc;
        while (cyc < c) begin
            acc = aud_in_rtr;
            tick(1);
            if (acc) begin
                n_acc++;
                aud_in = $urandom;
            end
        end
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_sck"},   32'(i2s_sck),       32'd0);
        check({tag, "_ws"},    32'(i2s_ws),        32'd0);
        check({tag, "_sd"},    32'(i2s_sd),        32'd0);
        check({tag, "_rtr"},   32'(aud_in_rtr),    32'd0);
        check({tag, "_level"}, 32'(ro_fifo_level), 32'd0);
    endtask

    initial begin
        int unsigned f0, e0, fs;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            tick(1);
            aud_in     = $urandom;
            aud_in_rts = 1'($urandom);
            rf_tx_en   = 1'($urandom);
            trig       = 1'($urandom);
        end
        chk_quiet("rst");
        check("rst_flag", 32'(ro_underrun_flag), 32'd0);
        aud_in_rts = 1'b0;
        trig       = 1'b0;
        rf_tx_en   = 1'b1;
        rstb       = 1'b1;
        check("rtr_before_first_edge", 32'(aud_in_rtr), 32'd0);
        tick(1);
        check("rtr_after_first_edge", 32'(aud_in_rtr), 32'd1);
        check("sck_idle", 32'(i2s_sck), 32'd0);

        // Single sample 0x8001_7FFE, then underrun frames.
        aud_in     = 32'h8001_7FFE;
        aud_in_rts = 1'b1;
        tick(1);
        aud_in_rts = 1'b0;
        check("a_level_after_push", 32'(ro_fifo_level), 32'd1);
        tick(1);
        f0 = cyc;
        check("a_level_popped", 32'(ro_fifo_level), 32'd0);
        check("a_slot0_sd", 32'(i2s_sd), 32'd1);
        check("a_slot0_ws", 32'(i2s_ws), 32'd0);
        check("a_slot0_sck", 32'(i2s_sck), 32'd0);
        wait_cyc(f0 + HALF_DIV - 1);
        check("a_sck_before_rise", 32'(i2s_sck), 32'd0);
        wait_cyc(f0 + HALF_DIV);
        check("a_first_sck_rise", 32'(i2s_sck), 32'd1);
        wait_cyc(f0 + SLOT);
        check("a_sck_period", 32'(i2s_sck), 32'd0);
        chk_slot(f0, 1,  1'b0, 1'b0);
        chk_slot(f0, 14, 1'b0, 1'b0);
        chk_slot(f0, 15, 1'b0, 1'b1);
        chk_slot(f0, 16, 1'b1, 1'b0);
        chk_slot(f0, 17, 1'b1, 1'b1);
        chk_slot(f0, 30, 1'b1, 1'b1);
        chk_slot(f0, 31, 1'b1, 1'b0);
        wait_cyc(f0 + FRAME - 1);
        check("a_flag_before_underrun", 32'(ro_underrun_flag), 32'd0);
        wait_cyc(f0 + FRAME);
        check("a_underrun_set", 32'(ro_underrun_flag), 32'd1);
        check("a_underrun_sd", 32'(i2s_sd), 32'd0);
        tick(3);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check("a_flag_cleared", 32'(ro_underrun_flag), 32'd0);
        wait_cyc(f0 + 2 * FRAME - 1);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check("a_set_beats_clear", 32'(ro_underrun_flag), 32'd1);

        // Back-to-back pushes with rts held from WAIT_FIRST.
        rf_tx_en = 1'b0;
        tick(1);
        check("b_rtr_disabled", 32'(aud_in_rtr), 32'd0);
        rf_tx_en = 1'b1;
        tick(1);
        e0 = cyc;
        check("b_rtr_enabled", 32'(aud_in_rtr), 32'd1);
        aud_in_rts = 1'b1;
        aud_in     = $urandom;
        n_acc      = 0;
        push_until(e0 + 12);
        check("b_accepted", 32'(n_acc), 32'd5);
        check("b_rtr_full", 32'(aud_in_rtr), 32'd0);
        check("b_level_full", 32'(ro_fifo_level), 32'd4);
        push_until(e0 + 2 + FRAME);
        check("b_accepted_pre", 32'(n_acc), 32'd5);
        check("b_level_after_pop", 32'(ro_fifo_level), 32'd3);
        check("b_rtr_after_pop", 32'(aud_in_rtr), 32'd1);
        push_until(e0 + 3 + FRAME);
        aud_in_rts = 1'b0;
        check("b_sixth_accepted", 32'(n_acc), 32'd6);
        check("b_level_refull", 32'(ro_fifo_level), 32'd4);

        // Disable at slot 10 with three samples buffered, then restart on a fresh sample.
        wait_cyc(e0 + 2 + 2 * FRAME + 10 * SLOT + 3);
        check("c_level_before_disable", 32'(ro_fifo_level), 32'd3);
        rf_tx_en = 1'b0;
        tick(1);
        chk_quiet("c_disabled");
        tick(5);
        rf_tx_en = 1'b1;
        tick(1);
        check("c_rtr_reenabled", 32'(aud_in_rtr), 32'd1);
        tick(10);
        check("c_idle_sck", 32'(i2s_sck), 32'd0);
        check("c_idle_level", 32'(ro_fifo_level), 32'd0);
        aud_in     = 32'hA5A5_3C3C;
        aud_in_rts = 1'b1;
        tick(1);
        aud_in_rts = 1'b0;
        tick(1);
        fs = cyc;
        check("c_restart_ws", 32'(i2s_ws), 32'd0);
        check("c_restart_sd", 32'(i2s_sd), 32'd1);
        check("c_restart_sck", 32'(i2s_sck), 32'd0);
        wait_cyc(fs + SLOT + HALF_DIV);
        check("c_restart_slot1_sd", 32'(i2s_sd), 32'd0);

        // Asynchronous reset between clock edges at slot 20.
        wait_cyc(fs + 20 * SLOT + 2);
        check("d_ws_before_reset", 32'(i2s_ws), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        chk_quiet("d_async_rst");
        check("d_async_rst_flag", 32'(ro_underrun_flag), 32'd0);
        tick(3);
        rf_tx_en = 1'b1;
        rstb     = 1'b1;

        // Randomized soak alternating a busy producer with a starving one.
        for (int i = 0; i < 6000; i++) begin
            aud_in_rts = ($urandom_range(0, 999) < (((i / 1500) % 2 == 0) ? 50 : 3));
            aud_in     = $urandom;
            trig       = ($urandom_range(0, 199) == 0);
            rf_tx_en   = ($urandom_range(0, 1999) != 0);
            tick(1);
        end
        aud_in_rts = 1'b0;
        trig       = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo audio sink on the far end of the filter output handshake. Accepts 32-bit stereo samples via rts/rtr into a small FIFO and serializes them as a left-justified I2S-style stream (sck, ws, sd) toward the external DAC. Reports FIFO underrun through a sticky flag cleared by a trigger pulse.

## Interface

- FIFO_DEPTH, 4: sample FIFO depth; power of 2, ≥2.
- PTR, 2: log2(FIFO_DEPTH).
- HALF_DIV, 4: clk cycles per sck half-period; ≥2.

- clk  in  1  system clock.
- rstb  in  1  reset; asynchronous, active-low.
- aud_in  in  32  stereo sample; [31:16] left, [15:0] right, two's complement.
- aud_in_rts  in  1  upstream ready to send.
- aud_in_rtr  out  1  ready to receive.
- rf_tx_en  in  1  transmitter enable.
- trig_underrun_flag_clear  in  1  one-cycle pulse; clears ro_underrun_flag.
- ro_underrun_flag  out  1  sticky underrun indicator.
- ro_fifo_level  out  PTR+1  current FIFO occupancy.
- i2s_sck  out  1  serial bit clock.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- i2s_sd  out  1  serial data, MSB first.

## Operation

- Transfer occurs on a clk rising edge where aud_in_rts && aud_in_rtr; sample written to FIFO tail.
- aud_in_rtr registered: next value = rf_tx_en && (level_nxt < FIFO_DEPTH). No combinational path from aud_in_rts.
- FIFO: wrptr/rdptr PTR bits, wrap modulo FIFO_DEPTH; level 0..FIFO_DEPTH. Simultaneous push and pop: level unchanged, both pointers advance.
- States: DISABLED, WAIT_FIRST, RUN.
  - DISABLED: rf_tx_en = 0. FIFO flushed (pointers, level = 0), counters cleared, sck/ws/sd = 0. rf_tx_en = 1 -> WAIT_FIRST.
  - WAIT_FIRST: idle outputs low, no underrun reporting. When level > 0, pop into 32-bit shift register, start slot 0 -> RUN.
  - RUN: serialize continuously. rf_tx_en = 0 in any state -> DISABLED on the next edge, mid-frame data discarded.
- Slot: 2*HALF_DIV clk cycles; sck low for the first HALF_DIV, high for the second; slot boundary = sck falling edge.
- Frame: 32 slots. Slots 0-15: ws = 0, sd = left[15..0]. Slots 16-31: ws = 1, sd = right[15..0]. MSB coincides with the ws transition (left-justified).
- Frame start (slot 31 -> 0): pop FIFO if level > 0; else load 0x0000_0000 and set ro_underrun_flag.
- ro_underrun_flag: set has priority over trig_underrun_flag_clear when both occur in the same cycle.
- Bit counter 5 bits, wraps 31 -> 0; divider counter 0..HALF_DIV-1.

## Timing

- Reset values: aud_in_rtr = 0, i2s_sck = 0, i2s_ws = 0, i2s_sd = 0, ro_underrun_flag = 0, ro_fifo_level = 0; state = DISABLED.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). FIFO contents are lost.
- aud_in_rtr rises 1 clk after the first edge with rstb high and rf_tx_en = 1.
- Latency: handshake at edge N into empty FIFO in WAIT_FIRST -> pop/load at N+1; ws/sd carry slot 0 (left MSB) from N+1; first sck rise at N+1+HALF_DIV.
- ws and sd change only at sck falling boundaries; stable across each sck rising edge.
- Frame period = 64*HALF_DIV clk; one FIFO pop per frame.
- ro_fifo_level updates the cycle after the push/pop edge.

## Test plan

- Reset: hold rstb low with random inputs -> all outputs 0; release with rf_tx_en = 1 -> aud_in_rtr = 1 one clk later, sck stays 0.
- Single sample 0x8001_7FFE, HALF_DIV = 4 -> sd = 1,0×14,1 with ws = 0, then 0,1×14,0 with ws = 1; sck period 8 clk; frame 256 clk.
- Back-to-back push with rts held -> 5 accepted (1 popped immediately, 4 buffered), rtr = 0 at level 4; the 6th is accepted one clk after the next frame-start pop.
- Underrun: one sample, then none -> frame 2 is all-zero sd and ro_underrun_flag = 1; a clear pulse -> 0; clear coincident with the next underrun -> flag stays 1.
- Disable mid-frame (slot 10) with level 3 -> next clk sck/ws/sd = 0, level 0, rtr = 0; re-enable -> idle until a new sample, then slot 0 starts with that sample.
- Async reset at slot 20 -> outputs cleared without a clk edge; operation resumes normally after release.
